handshake_bus_arbiter: RTL

//  Shares one 16-bit send/ack output channel between two processor-side requesters.
//  - Fair round-robin choice of requester.
//  - Drives a 4-phase send/ack handshake to the downstream consumer.
//  - Reports completion (done) or timeout (err) to the granted requester.
//  - Sits between processor FSMs and a single consumer port.

---
 rtl/handshake_bus_arbiter_pkg.sv | 20 ++
 rtl/handshake_bus_arbiter_if.sv | 30 +++
 rtl/handshake_bus_arbiter_rr_pick2.sv | 11 +
 rtl/handshake_bus_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/handshake_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester send/ack bus arbiter.
// Also provides the one-hot helper used to encode the winning requester.
package handshake_bus_arbiter_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DROP,
    DONE,
    ABORT
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/handshake_bus_arbiter_if.sv
// Requester/consumer signal bundle of the arbiter.
// The master side is the arbiter itself; the slave side is its environment.
interface handshake_bus_arbiter_if
  import handshake_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]        req;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic [1:0]        err;
  logic              send;
  logic [DATA_W-1:0] dado;
  logic              ack;
  logic              busy;

  modport master (
    input  req, din0, din1, ack,
    output grant, done, err, send, dado, busy
  );

  modport slave (
    output req, din0, din1, ack,
    input  grant, done, err, send, dado, busy
  );

endinterface

// File: rtl/handshake_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: the preferred requester wins a tie.
// Output is only meaningful while at least one request bit is set.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_winner
);

  assign o_winner = i_req[i_ptr] ? i_ptr : ~i_ptr;

endmodule

// File: rtl/handshake_bus_arbiter.sv
// Shares one send/ack output channel between two requesters with round-robin
// fairness, a 4-phase downstream handshake and an optional phase timeout.
module handshake_bus_arbiter
  import handshake_bus_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_bus_arbiter_if.master bus
);

  localparam int              TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TMO_EN   = (TIMEOUT != 0);

  arb_state_t        r_state;
  logic              r_ptr;
  logic              r_winner;
  logic [1:0]        r_grant;
  logic [1:0]        r_done;
  logic [1:0]        r_err;
  logic              r_send;
  logic              r_busy;
  logic [DATA_W-1:0] r_dado;
  logic [TMR_W-1:0]  r_timer;

  logic w_pick;
  logic w_expired;

  rr_pick2 u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick)
  );

  // The timer restarts on every phase entry, so it can never pass TMR_LAST.
  assign w_expired = TMO_EN && (r_timer == TMR_LAST);

  // NOTE: state is updated only with non-blocking assignments so every branch
  // reads the pre-edge values of r_timer/r_winner regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_winner <= 1'b0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_send   <= 1'b0;
      r_busy   <= 1'b0;
      // NOTE: the data register is reset as well because dado is visible at
      // the port and its post-reset value is defined as zero.
      r_dado   <= '0;
      r_timer  <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            r_winner <= w_pick;
            r_dado   <= w_pick ? bus.din1 : bus.din0;
            r_grant  <= onehot2(w_pick);
            r_send   <= 1'b1;
            r_busy   <= 1'b1;
            r_timer  <= '0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (bus.ack) begin
            r_send  <= 1'b0;
            r_timer <= '0;
            r_state <= DROP;
          end else if (w_expired) begin
            r_send  <= 1'b0;
            r_err   <= onehot2(r_winner);
            r_state <= ABORT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DROP: begin
          if (!bus.ack) begin
            r_done  <= onehot2(r_winner);
            r_state <= DONE;
          end else if (w_expired) begin
            r_err   <= onehot2(r_winner);
            r_state <= ABORT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE, ABORT: begin
          // Grant is held through the done/err cycle so the owner can qualify it.
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= ~r_winner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.send  = r_send;
  assign bus.dado  = r_dado;
  assign bus.busy  = r_busy;

endmodule
